dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 158 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one load/store at a time through IDLE -> BUSY -> RESP,
// with a configurable number of wait states. Define DMEM_ERR_EN to enable fault checking.
module dmem_ctrl #(
    parameter int WORDS       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t         state;
    logic [2:0]     wait_cnt;
    logic           cap_we;
    logic [2:0]     cap_funct3;
    logic [31:0]    cap_addr;
    logic [31:0]    cap_wdata;

    logic [31:0]    mem [WORDS];
    logic [AW-1:0]  idx;
    logic [31:0]    word;

    logic [3:0]     be;
    logic [31:0]    wlanes;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [31:0]    load_val;
    logic           fault;
    logic           access;
    logic           do_write;

    assign idx       = cap_addr[AW+1:2];
    assign word      = mem[idx];
    assign req_ready = (state == IDLE) && rst_n;
    assign access    = (state == BUSY) && (wait_cnt == 3'd0);
    assign do_write  = access && cap_we && !fault;

    // Lane selection for both directions; narrow stores replicate data across lanes
    // so the byte enables alone pick the destination.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        be       = 4'b1111;
        wlanes   = cap_wdata;
        byte_sel = word[{cap_addr[1:0], 3'b000} +: 8];
        half_sel = cap_addr[1] ? word[31:16] : word[15:0];
        load_val = word;
        case (cap_funct3)
            3'b000, 3'b100: begin
                be       = 4'b0001 << cap_addr[1:0];
                wlanes   = {4{cap_wdata[7:0]}};
                load_val = {{24{byte_sel[7] & ~cap_funct3[2]}}, byte_sel};
            end
            3'b001, 3'b101: begin
                be       = cap_addr[1] ? 4'b1100 : 4'b0011;
                wlanes   = {2{cap_wdata[15:0]}};
                load_val = {{16{half_sel[15] & ~cap_funct3[2]}}, half_sel};
            end
            default: begin
                be       = 4'b1111;
                wlanes   = cap_wdata;
                load_val = word;
            end
        endcase
    end

`ifdef DMEM_ERR_EN
    always_comb begin
        fault = 1'b0;
        case (cap_funct3)
            3'b001, 3'b101: fault = cap_addr[0];
            3'b010:         fault = (cap_addr[1:0] != 2'b00);
            3'b011, 3'b110, 3'b111: fault = 1'b1;
            default:        fault = 1'b0;
        endcase
        if (|cap_addr[31:AW+2])
            fault = 1'b1;
    end
`else
    // Without fault checking the upper address bits simply wrap the index.
    logic unused_hi;
    assign unused_hi = |cap_addr[31:AW+2];
    assign fault     = 1'b0;
`endif

    // NOTE: the array has no reset; its contents survive rst_n and start undefined.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= 3'd0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
            cap_we     <= 1'b0;
            cap_funct3 <= 3'd0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we     <= req_we;
                        cap_funct3 <= req_funct3;
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                        wait_cnt   <= 3'(WAIT_STATES);
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else begin
                        rsp_rdata <= (cap_we || fault) ? 32'd0 : load_val;
                        rsp_err   <= fault;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus random traffic checked
// against a byte-addressed reference memory; follows DMEM_ERR_EN like the design.
module tb_dmem_ctrl;

    localparam int WORDS = 256;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mb [WORDS*4];

    dmem_ctrl #(.WORDS(WORDS), .WAIT_STATES(WS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: little-endian byte memory, access size from funct3.
    task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int size;
        bit uns;
        bit illegal;
        int base;
        logic [31:0] val;
        uns = 1'b0;
        illegal = 1'b0;
        case (f3)
            3'b000: size = 1;
            3'b001: size = 2;
            3'b010: size = 4;
            3'b100: begin size = 1; uns = 1'b1; end
            3'b101: begin size = 2; uns = 1'b1; end
            default: begin size = 4; illegal = 1'b1; end
        endcase
        err = 1'b0;
`ifdef DMEM_ERR_EN
        err = illegal || ((int'(addr[1:0]) % size) != 0) || ((addr >> 2) >= 32'(WORDS));
`endif
        base = int'((addr >> 2) % 32'(WORDS)) * 4 + (int'(addr[1:0]) / size) * size;
        rd = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++)
                    mb[base+i] = wd[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < size; i++)
                    val = val | (32'(mb[base+i]) << (8*i));
                if (!uns && size < 4 && val[8*size-1])
                    val = val | ~((32'd1 << (8*size)) - 32'd1);
                rd = val;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          waited;
        int          edges;
        model_op(we, f3, addr, wd, exp_rd, exp_err);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Garbage on the request bus while busy must be ignored.
        req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end while (!rsp_valid && edges < 20);
        check({tag, "_latency"}, 32'(edges), 32'(WS + 1));
        check({tag, "_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, "_ready_in_resp"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_pulse_width"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rdata_hold"}, rsp_rdata, exp_rd);
        check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] b2b_addr [3];
        logic [31:0] b2b_exp [3];
        int          acc_cyc [3];
        int          n_acc;
        int          n_rsp;
        bit          pend;
        int          pulses;

        #3;
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_ready", 32'(req_ready), 32'd1);

        for (int w = 0; w < WORDS; w++)
            do_req(1'b1, 3'b010, 32'(w * 4), $urandom, "init");

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw_10");
        do_req(1'b0, 3'b010, 32'h10, 32'h0, "lw_10");
        do_req(1'b1, 3'b000, 32'h13, 32'h000000A5, "sb_13");
        do_req(1'b0, 3'b010, 32'h10, 32'h0, "lw_10_after_sb");
        do_req(1'b0, 3'b000, 32'h13, 32'h0, "lb_13");
        do_req(1'b0, 3'b100, 32'h13, 32'h0, "lbu_13");
        do_req(1'b1, 3'b001, 32'h12, 32'h00008001, "sh_12");
        do_req(1'b0, 3'b001, 32'h12, 32'h0, "lh_12");
        do_req(1'b0, 3'b101, 32'h12, 32'h0, "lhu_12");
        do_req(1'b0, 3'b010, 32'h10, 32'h0, "lw_10_after_sh");
        do_req(1'b0, 3'b010, 32'h11, 32'h0, "lw_misaligned");
        do_req(1'b1, 3'b010, 32'h400, 32'h12345678, "sw_400");
        do_req(1'b0, 3'b011, 32'h14, 32'h0, "ld_funct3_011");
        do_req(1'b1, 3'b001, 32'h11, 32'hCAFE, "sh_misaligned");
        do_req(1'b0, 3'b010, 32'h0, 32'h0, "lw_0");

        // Reset during BUSY must abort the store and suppress the response.
        do_req(1'b1, 3'b010, 32'h20, 32'h11111111, "sw_20");
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h22222222;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(req_ready), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rdata", rsp_rdata, 32'd0);
        check("abort_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("abort_no_rsp", 32'(pulses), 32'd0);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, "lw_20_after_abort");

        // Back-to-back loads with req_valid held high.
        for (int k = 0; k < 3; k++) begin
            b2b_addr[k] = 32'(($urandom % WORDS) * 4);
            model_op(1'b0, 3'b010, b2b_addr[k], 32'h0, exp_rd, exp_err);
            b2b_exp[k] = exp_rd;
            acc_cyc[k] = -1;
        end
        n_acc = 0;
        n_rsp = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                req_we = 1'b0; req_funct3 = 3'b010; req_addr = b2b_addr[0]; req_valid = 1'b1;
            end
            if (pend) begin
                pend = 1'b0;
                if (n_acc < 3) req_addr = b2b_addr[n_acc];
                else req_valid = 1'b0;
            end
            if (rsp_valid) begin
                if (n_rsp < 3) check("b2b_rdata", rsp_rdata, b2b_exp[n_rsp]);
                n_rsp++;
            end
            if (req_ready && req_valid && n_acc < 3) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                pend = 1'b1;
            end
        end
        req_valid = 1'b0;
        check("b2b_accepts", 32'(n_acc), 32'd3);
        check("b2b_responses", 32'(n_rsp), 32'd3);
        check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(WS + 3));
        check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(WS + 3));

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = ($urandom % 8 == 0) ? $urandom : ($urandom % (WORDS * 4));
            do_req(1'($urandom), 3'($urandom), a, $urandom, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
